// File: rtl/sr_drv_pkg.sv
// rtl/sr_drv_pkg.sv - shared types and defaults for the SR latch write driver
package sr_drv_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    PULSE = 3'd2,
    HOLD  = 3'd3,
    CHECK = 3'd4
  } state_t;

  localparam int DEF_SETUP_CYC = 1;
  localparam int DEF_PULSE_CYC = 4;
  localparam int DEF_HOLD_CYC  = 1;

  // {s, r, en} for a phase; r is always ~s while driving, so s=r=1 cannot occur
  function automatic logic [2:0] phase_drive(input state_t st, input logic v);
    logic [2:0] d;
    d = 3'b000;
    case (st)
      SETUP, HOLD: d = {v, ~v, 1'b0};
      PULSE:       d = {v, ~v, 1'b1};
      default:     d = 3'b000;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/sr_phase_counter.sv
// rtl/sr_phase_counter.sv - loadable down-counter timing each latch drive phase
module sr_phase_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/sr_latch_driver.sv
// rtl/sr_latch_driver.sv - turns a one-bit write request into a timed s/r/en sequence
module sr_latch_driver
  import sr_drv_pkg::*;
#(
  parameter int SETUP_CYC = DEF_SETUP_CYC,
  parameter int PULSE_CYC = DEF_PULSE_CYC,
  parameter int HOLD_CYC  = DEF_HOLD_CYC,
  parameter int CNT_W     = 8,
  parameter int SKIP_SAME = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic req_valid,
  input  logic req_value,
  output logic req_ready,
  input  logic q_fb,
  output logic s,
  output logic r,
  output logic en,
  output logic done,
  output logic err
);

  if (SETUP_CYC < 1 || PULSE_CYC < 1 || HOLD_CYC < 1 ||
      SETUP_CYC > 2**CNT_W || PULSE_CYC > 2**CNT_W || HOLD_CYC > 2**CNT_W) begin : g_bad_cyc
    $error("sr_latch_driver: phase lengths must be in 1..2**CNT_W");
  end

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);

  state_t           state, state_n;
  logic             val, val_n;
  logic             shadow, shadow_valid;
  logic             accept;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_load_val;
  logic [2:0]       drive_n;
  logic             err_n;

  assign accept = req_valid && req_ready;

  sr_phase_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_n      = state;
    val_n        = val;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          val_n = req_value;
          if (SKIP_SAME != 0 && shadow_valid && (req_value == shadow)) begin
            state_n = CHECK;
          end else begin
            state_n      = SETUP;
            cnt_load     = 1'b1;
            cnt_load_val = SETUP_LD;
          end
        end
      end
      SETUP: begin
        if (cnt_zero) begin
          state_n      = PULSE;
          cnt_load     = 1'b1;
          cnt_load_val = PULSE_LD;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      PULSE: begin
        if (cnt_zero) begin
          state_n      = HOLD;
          cnt_load     = 1'b1;
          cnt_load_val = HOLD_LD;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      HOLD: begin
        if (cnt_zero) begin
          state_n = CHECK;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      CHECK:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered pins line up with the state
  assign drive_n = phase_drive(state_n, val_n);
  assign err_n   = (state_n == CHECK) && (q_fb != val_n);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      val          <= 1'b0;
      shadow       <= 1'b0;
      shadow_valid <= 1'b0;
      s            <= 1'b0;
      r            <= 1'b0;
      en           <= 1'b0;
      req_ready    <= 1'b1;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      state       <= state_n;
      val         <= val_n;
      {s, r, en}  <= drive_n;
      req_ready   <= (state_n == IDLE);
      done        <= (state_n == CHECK);
      err         <= err_n;
      if (state_n == CHECK) begin
        if (err_n) begin
          shadow_valid <= 1'b0;
        end else begin
          shadow       <= val_n;
          shadow_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sr_latch_driver.sv
// tb/tb_sr_latch_driver.sv - scoreboard bench for three driver configurations
module tb_sr_latch_driver;

  typedef struct {
    int   id;
    logic err;
    int   lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_value = 1'b0;
  logic [2:0] vld = '0;
  logic [2:0] stuck = '0;
  logic [2:0] q_m = '0;
  logic [2:0] q_fb_w, ready_w, s_w, r_w, en_w, done_w, err_w;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   sr_bad = 0, err_bad = 0, rdy_bad = 0;
  int   en_run[3], sr_run[3], pulse_cnt[3], acc_cyc[3], last_done[3];
  bit   busy[3], ign[3], en_prev[3];
  int   setup_exp[3] = '{1, 1, 3};
  int   pulse_exp[3] = '{4, 4, 1};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign q_fb_w = q_m & ~stuck;

  sr_latch_driver u_dut0 (
    .clk(clk), .rst(rst), .req_valid(vld[0]), .req_value(req_value), .req_ready(ready_w[0]),
    .q_fb(q_fb_w[0]), .s(s_w[0]), .r(r_w[0]), .en(en_w[0]), .done(done_w[0]), .err(err_w[0])
  );

  sr_latch_driver #(.SKIP_SAME(1)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(vld[1]), .req_value(req_value), .req_ready(ready_w[1]),
    .q_fb(q_fb_w[1]), .s(s_w[1]), .r(r_w[1]), .en(en_w[1]), .done(done_w[1]), .err(err_w[1])
  );

  sr_latch_driver #(.SETUP_CYC(3), .PULSE_CYC(1), .HOLD_CYC(2)) u_dut2 (
    .clk(clk), .rst(rst), .req_valid(vld[2]), .req_value(req_value), .req_ready(ready_w[2]),
    .q_fb(q_fb_w[2]), .s(s_w[2]), .r(r_w[2]), .en(en_w[2]), .done(done_w[2]), .err(err_w[2])
  );

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Gated SR latch model
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (en_w[i]) q_m[i] <= s_w[i] ? 1'b1 : (r_w[i] ? 1'b0 : q_m[i]);
    end
  end

  // Monitor: scoreboard pops on done, plus phase-shape checks per instance
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (s_w[i] && r_w[i]) sr_bad++;
      if (!done_w[i] && err_w[i]) err_bad++;
      if (busy[i] && ready_w[i]) rdy_bad++;
      if (done_w[i]) begin
        if (sb.size() == 0) begin
          check($sformatf("unexpected_done_dut%0d", i), 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("sb_dut_id", i, e.id);
          check($sformatf("sb_err_dut%0d", i), err_w[i], e.err);
          check($sformatf("sb_latency_dut%0d", i), cyc - acc_cyc[i], e.lat);
        end
        last_done[i] = cyc;
        busy[i] = 1'b0;
      end
      if (en_w[i] && !en_prev[i]) begin
        pulse_cnt[i]++;
        if (!ign[i]) check($sformatf("setup_len_dut%0d", i), sr_run[i], setup_exp[i]);
      end
      if (en_w[i]) begin
        en_run[i]++;
      end else if (en_run[i] != 0) begin
        if (!ign[i]) check($sformatf("pulse_len_dut%0d", i), en_run[i], pulse_exp[i]);
        en_run[i] = 0;
      end
      if (s_w[i] || r_w[i]) begin
        sr_run[i]++;
      end else if (sr_run[i] != 0) begin
        if (!ign[i]) check($sformatf("sr_len_dut%0d", i), sr_run[i], 6);
        sr_run[i] = 0;
      end
      en_prev[i] = en_w[i];
      if (rst && (s_w[i] || r_w[i] || en_w[i])) ign[i] = 1'b1;
      else if (!(s_w[i] || r_w[i] || en_w[i])) ign[i] = 1'b0;
      if (rst) begin
        busy[i] = 1'b0;
      end else if (vld[i] && ready_w[i]) begin
        acc_cyc[i] = cyc;
        busy[i] = 1'b1;
      end
    end
  end

  task automatic write(input int id, input logic v, input logic e, input int lat,
                       input bit push, input bit hold, output int acc);
    exp_t t;
    if (push) begin
      t.id = id; t.err = e; t.lat = lat;
      sb.push_back(t);
    end
    req_value = v;
    vld[id] = 1'b1;
    acc = -1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (ready_w[id]) begin
        acc = cyc;
        break;
      end
    end
    if (acc < 0) check("accept_timeout", 0, 1);
    @(posedge clk); #1;
    if (!hold) vld[id] = 1'b0;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    if (sb.size() != 0) check("done_timeout", sb.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int a1, a2, p, k;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_s", s_w[0], 0);
    check("reset_r", r_w[0], 0);
    check("reset_en", en_w[0], 0);
    check("reset_ready", ready_w[0], 1);
    check("reset_done", done_w[0], 0);
    check("reset_err", err_w[0], 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Default timing, write 1 then back-to-back 0/1 with valid held high
    write(0, 1'b1, 1'b0, 7, 1, 0, a1);
    wait_done();
    write(0, 1'b0, 1'b0, 7, 1, 1, a1);
    write(0, 1'b1, 1'b0, 7, 1, 0, a2);
    check("b2b_gap", a2 - last_done[0], 1);
    wait_done();

    // Reset during the second enable cycle aborts the write silently
    write(0, 1'b0, 1'b0, 7, 0, 0, a1);
    k = 0;
    while (!en_w[0] && k < 30) begin
      @(negedge clk);
      k++;
    end
    check("abort_saw_en", en_w[0], 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_s", s_w[0], 0);
    check("abort_r", r_w[0], 0);
    check("abort_en", en_w[0], 0);
    check("abort_ready", ready_w[0], 1);
    repeat (10) @(negedge clk);
    @(posedge clk); #1;
    write(0, 1'b1, 1'b0, 7, 1, 0, a1);
    wait_done();

    // SKIP_SAME instance: failed write clears the shadow, then skip hit and miss
    stuck[1] = 1'b1;
    write(1, 1'b1, 1'b1, 7, 1, 0, a1);
    wait_done();
    stuck[1] = 1'b0;
    write(1, 1'b1, 1'b0, 7, 1, 0, a1);
    wait_done();
    p = pulse_cnt[1];
    write(1, 1'b1, 1'b0, 1, 1, 0, a1);
    wait_done();
    check("skip_no_pulse", pulse_cnt[1], p);
    write(1, 1'b0, 1'b0, 7, 1, 0, a1);
    wait_done();
    check("skip_miss_pulsed", pulse_cnt[1], p + 1);

    // Asymmetric phase lengths
    write(2, 1'b1, 1'b0, 7, 1, 0, a1);
    wait_done();
    write(2, 1'b0, 1'b0, 7, 1, 0, a1);
    wait_done();

    repeat (3) @(negedge clk);
    check("s_and_r_never_both", sr_bad, 0);
    check("err_only_with_done", err_bad, 0);
    check("ready_low_while_busy", rdy_bad, 0);
    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sr_latch_driver.md
Name: sr_latch_driver

Overview:
- Clocked write-side driver for a gated SR latch (inputs s/r/en; outputs q/qbar).
- Accepts a desired bit over a valid/ready handshake and converts it into a timed s/r/en pulse sequence.
  - s/r are set up before en rises, en is held high for a programmable width, and s/r are held after en falls.
- Checks the latch feedback q and reports completion and error.
- Guarantees the forbidden s=r=1 combination is never driven.

Parameters:
- SETUP_CYC, 1: cycles s/r are stable with en=0 before en rises (must be >=1).
- PULSE_CYC, 4: cycles en is high (must be >=1).
- HOLD_CYC, 1: cycles s/r are held with en=0 after en falls (must be >=1).
- CNT_W, 8: phase counter width. Each *_CYC must be <= 2**CNT_W.
- SKIP_SAME, 0: 1 = a request equal to the last successfully written value completes without pulsing.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  write request valid
- req_value  in  1  bit to store (1=set, 0=reset)
- req_ready  out  1  driver can accept a request
- q_fb  in  1  latch q feedback
- s  out  1  latch set input
- r  out  1  latch reset input
- en  out  1  latch enable
- done  out  1  one-cycle completion strobe
- err  out  1  valid with done; 1 = q_fb != requested value

Behaviour:
- Outputs are registered. Reset values: s=0, r=0, en=0, req_ready=1, done=0, err=0. Reset also sets state=IDLE, shadow_valid=0 and counter=0.
- States: IDLE, SETUP, PULSE, HOLD, CHECK.
- IDLE:
  - Drives s=r=en=0 and req_ready=1.
  - On req_valid&&req_ready, captures req_value into val.
  - If SKIP_SAME=1, shadow_valid=1 and val==shadow, goes directly to CHECK.
  - Otherwise goes to SETUP with counter=SETUP_CYC-1.
- SETUP: s=val, r=~val, en=0. Counter decrements; at 0, goes to PULSE with counter=PULSE_CYC-1.
- PULSE: s=val, r=~val, en=1. At counter 0, goes to HOLD with counter=HOLD_CYC-1.
- HOLD: s=val, r=~val, en=0. At counter 0, goes to CHECK.
- CHECK:
  - s=r=en=0; done=1 for exactly this cycle; err=(q_fb!=val).
  - If err=0: shadow=val and shadow_valid=1. If err=1: shadow_valid=0.
  - Next state is IDLE.
- req_ready=0 in every state except IDLE. req_valid outside IDLE is ignored, not queued.
- Latency: request accepted on edge T gives done high during cycle T+SETUP_CYC+PULSE_CYC+HOLD_CYC+1 (7 with defaults). A SKIP_SAME hit gives done at T+1.
- Throughput: the next request is accepted in the IDLE cycle immediately after CHECK, so back-to-back requests are separated by one idle cycle.
- Invariant: s&r==0 in every cycle, including the reset cycle and state transitions.
- Invariant: en=1 only in PULSE, for exactly PULSE_CYC consecutive cycles per write.
- rst mid-operation: all outputs take reset values at that edge. No done is generated for the aborted write. shadow_valid clears.
- err is 0 whenever done=0.
- Parameter value 0 for any *_CYC is an elaboration error.

Decomposition:
- Package sr_drv_pkg holds:
  - state enum state_t {IDLE, SETUP, PULSE, HOLD, CHECK}
  - localparam defaults for the three phase lengths
- One sub-module is natural: sr_phase_counter, a loadable down-counter of CNT_W bits with load, load_val, dec and a zero flag. The FSM loads it on each phase entry.

Test Plan:
- Write 1 after reset (q_fb models the latch) -> s=1,r=0 for 6 cycles; en=1 for exactly 4 cycles starting 1 cycle after s rises; done=1,err=0 at T+7; req_ready=0 from T+1 to T+7.
- Write 0, then write 1 back-to-back with req_valid held high -> second accept occurs 1 cycle after first done; s/r swap; s&r never 1 (assert every cycle).
- Write 1 with q_fb stuck at 0 -> done=1,err=1 at T+7; a following write 1 with SKIP_SAME=1 still pulses because shadow_valid=0.
- SKIP_SAME=1: write 1 succeeds, write 1 again -> en never rises, done=1,err=0 at T+1; write 0 -> full 7-cycle sequence.
- rst asserted during PULSE (2nd en cycle) -> next edge s=r=en=0, req_ready=1; no done observed; a new write completes normally.
- SETUP_CYC=3, PULSE_CYC=1, HOLD_CYC=2 -> en high exactly 1 cycle, 3 cycles after s/r valid; done at T+7.
